cake_pos_gen: RTL and testbench

- Producer side of the food-placement interface.
- Watches the snake head against the current cake position and detects an eat event.
- On an eat, computes a new grid-aligned random position from a free-running LFSR, rejecting any candidate that lands on the head or the old cake.
- Delivers the position over the two-beat rand_num/rand_drive protocol: X on the rand_drive beat, Y on the following cycle. The cake placement block latches it into rand_x/rand_y.

---
 rtl/cake_pos_gen.sv | 117 +++++++++++
 tb/tb_cake_pos_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cake_pos_gen.sv
// cake_pos_gen: detects the snake eating the cake and sends a new random grid position
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   game_en               enables eat detection (the LFSR always runs)
//   head_x/head_y         snake head position in pixels
//   cake_x/cake_y         current cake position fed back from the placement block
//   rand_num              X on the rand_drive cycle, Y on the cycle after
//   rand_drive            one-cycle strobe marking the X beat
//   eat_pulse             one-cycle strobe per eat
//   score                 eat counter, wraps 255 -> 0
module cake_pos_gen #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          CELL_SHIFT = 3,
    parameter int          X_LIMIT    = 440,
    parameter int          Y_LIMIT    = 320,
    parameter int          MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_en,
    input  logic [11:0] head_x,
    input  logic [11:0] head_y,
    input  logic [11:0] cake_x,
    input  logic [11:0] cake_y,
    output logic [8:0]  rand_num,
    output logic        rand_drive,
    output logic        eat_pulse,
    output logic [7:0]  score
);
    typedef enum logic [2:0] {IDLE, CALC, CHECK, SEND_X, SEND_Y, HOLD} state_t;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    state_t        state, state_nx;
    logic [15:0]   lfsr, lfsr_nx;
    logic [RW-1:0] retry_cnt, retry_nx;
    logic [8:0]    cand_x, cand_y, cand_x_nx, cand_y_nx, map_x, map_y, rand_num_nx;
    logic          rand_drive_nx, eat_pulse_nx, hit, collide;
    logic [7:0]    score_nx;

    // Snap to the grid, then fold values past the limit back into range;
    // one subtraction is enough because the limit is at least half of 512.
    function automatic logic [8:0] map_cand(input logic [8:0] raw, input int limit);
        logic [9:0] a;
        a = {1'b0, (raw >> CELL_SHIFT) << CELL_SHIFT};
        return (a >= 10'(limit)) ? 9'(a - 10'(limit)) : a[8:0];
    endfunction

    assign map_x   = map_cand(lfsr[8:0], X_LIMIT);
    assign map_y   = map_cand(lfsr[15:7], Y_LIMIT);
    assign lfsr_nx = (lfsr == 16'd0) ? SEED : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));
    assign hit     = game_en && head_x == cake_x && head_y == cake_y;
    assign collide = ({3'b0, cand_x} == head_x && {3'b0, cand_y} == head_y) ||
                     ({3'b0, cand_x} == cake_x && {3'b0, cand_y} == cake_y);

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        state_nx      = state;
        retry_nx      = retry_cnt;
        cand_x_nx     = cand_x;
        cand_y_nx     = cand_y;
        rand_num_nx   = rand_num;
        rand_drive_nx = 1'b0;
        eat_pulse_nx  = 1'b0;
        score_nx      = score;
        case (state)
            IDLE: if (hit) begin
                state_nx     = CALC;
                eat_pulse_nx = 1'b1;
                score_nx     = score + 8'd1;
                retry_nx     = '0;
            end
            CALC: begin
                cand_x_nx = map_x;
                cand_y_nx = map_y;
                state_nx  = CHECK;
            end
            CHECK: if (collide && retry_cnt < RW'(MAX_RETRY)) begin
                retry_nx = retry_cnt + 1'b1;
                state_nx = CALC;
            end else begin
                state_nx      = SEND_X;
                rand_num_nx   = cand_x;
                rand_drive_nx = 1'b1;
            end
            SEND_X: begin
                state_nx    = SEND_Y;
                rand_num_nx = cand_y;
            end
            SEND_Y:  state_nx = HOLD;
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED;
            retry_cnt  <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            rand_num   <= '0;
            rand_drive <= 1'b0;
            eat_pulse  <= 1'b0;
            score      <= '0;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            retry_cnt  <= retry_nx;
            cand_x     <= cand_x_nx;
            cand_y     <= cand_y_nx;
            rand_num   <= rand_num_nx;
            rand_drive <= rand_drive_nx;
            eat_pulse  <= eat_pulse_nx;
            score      <= score_nx;
        end
    end
endmodule

// File: tb/tb_cake_pos_gen.sv
// tb_cake_pos_gen: directed/random checks of cake_pos_gen against a position-sequence model
module tb_cake_pos_gen;
    localparam logic [15:0] SEED = 16'hACE1;
    logic clk = 1'b0, rst_n, game_en;
    logic [11:0] head_x, head_y, cake_x, cake_y;
    logic [8:0] rand_num, rand_num_nr;
    logic rand_drive, eat_pulse, rand_drive_nr, eat_pulse_nr;
    logic [7:0] score, score_nr;
    int n_cmp = 0, n_fail = 0, cyc = 0, tot_ep = 0, tot_rd = 0;
    logic [7:0] exp_score = 8'd0;

    cake_pos_gen dut (.clk(clk), .rst_n(rst_n), .game_en(game_en), .head_x(head_x), .head_y(head_y),
        .cake_x(cake_x), .cake_y(cake_y), .rand_num(rand_num), .rand_drive(rand_drive),
        .eat_pulse(eat_pulse), .score(score));
    cake_pos_gen #(.MAX_RETRY(0)) dut_nr (.clk(clk), .rst_n(rst_n), .game_en(game_en), .head_x(head_x),
        .head_y(head_y), .cake_x(cake_x), .cake_y(cake_y), .rand_num(rand_num_nr),
        .rand_drive(rand_drive_nr), .eat_pulse(eat_pulse_nr), .score(score_nr));

    always #5 clk = ~clk;
    // Non-reset cycles elapsed since the last reset edge.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Value of the x^16+x^14+x^13+x^11+1 sequence n steps after the seed.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    function automatic logic [8:0] cand(input logic [8:0] raw, input int lim);
        int a;
        a = (int'(raw) / 8) * 8;
        return (a >= lim) ? 9'(a - lim) : 9'(a);
    endfunction

    // Position the block should send when its first candidate is drawn at cycle c.
    task automatic predict(input int c, input int maxr, input logic [11:0] hx, hy, cx, cy,
                           output int k, output logic [8:0] px, py);
        logic [15:0] l;
        k = 0;
        forever begin
            l  = lfsr_at(c + 2 * k);
            px = cand(l[8:0], 440);
            py = cand(l[15:7], 320);
            if ((({3'b0, px} == hx && {3'b0, py} == hy) || ({3'b0, px} == cx && {3'b0, py} == cy)) && k < maxr)
                k++;
            else
                break;
        end
    endtask

    task automatic do_eat(input bit force_retry, input bit rst_mid);
        int t, c, k_m, k_n, d_m, d_n, ep_cnt, rd_m, rd_n;
        logic [8:0] ex_x, ex_y, en_x, en_y, c0x, c0y, gx, gy, nx, ny;
        logic [15:0] l0;
        head_x = cake_x;
        head_y = cake_y;
        t = 0;
        do begin @(negedge clk); t++; end while (!eat_pulse && t < 5);
        chk("eat_detect", eat_pulse, 1);
        if (!eat_pulse) return;
        exp_score = exp_score + 8'd1;
        chk("score_on_eat", score, exp_score);
        tot_ep++;
        c   = cyc;
        l0  = lfsr_at(c);
        c0x = cand(l0[8:0], 440);
        c0y = cand(l0[15:7], 320);
        head_x = force_retry ? {3'b0, c0x} : 12'hFFF;
        head_y = force_retry ? {3'b0, c0y} : 12'hFFF;
        predict(c, 3, head_x, head_y, cake_x, cake_y, k_m, ex_x, ex_y);
        predict(c, 0, head_x, head_y, cake_x, cake_y, k_n, en_x, en_y);
        {d_m, d_n, ep_cnt, rd_m, rd_n} = '0;
        {gx, gy, nx, ny} = '0;
        for (t = 1; t <= 12; t++) begin
            @(negedge clk);
            ep_cnt += int'(eat_pulse);
            if (d_m != 0 && t == d_m + 1) gy = rand_num;
            if (d_n != 0 && t == d_n + 1) ny = rand_num_nr;
            if (rand_drive) begin
                rd_m++;
                if (d_m == 0) begin d_m = t; gx = rand_num; end
                if (rst_mid) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    chk("rst_mid_drive", rand_drive, 0);
                    chk("rst_mid_num", rand_num, 0);
                    chk("rst_mid_score", score, 0);
                    chk("rst_mid_eat", eat_pulse, 0);
                    chk("rst_mid_lfsr", dut.lfsr, SEED);
                    rst_n     = 1'b1;
                    exp_score = 8'd0;
                    head_x    = 12'hFFF;
                    head_y    = 12'hFFF;
                    return;
                end
            end
            if (rand_drive_nr) begin
                rd_n++;
                if (d_n == 0) begin d_n = t; nx = rand_num_nr; end
            end
        end
        tot_ep += ep_cnt;
        tot_rd += rd_m;
        chk("eat_single_cycle", ep_cnt, 0);
        chk("drive_count", rd_m, 1);
        chk("drive_latency", d_m, 2 + 2 * k_m);
        chk("x_value", gx, ex_x);
        chk("y_value", gy, ex_y);
        chk("x_grid", gx[2:0], 0);
        chk("x_range", gx < 9'd440, 1);
        chk("y_grid", gy[2:0], 0);
        chk("y_range", gy < 9'd320, 1);
        chk("nr_drive_count", rd_n, 1);
        chk("nr_latency", d_n, 2 + 2 * k_n);
        chk("nr_x_value", nx, en_x);
        chk("nr_y_value", ny, en_y);
        chk("score_hold", score, exp_score);
        if (force_retry) begin
            chk("retry_latency_grows", d_m > 2, 1);
            chk("retry_new_pos", gx != c0x || gy != c0y, ex_x != c0x || ex_y != c0y);
            chk("nr_sends_collision", {nx, ny}, {c0x, c0y});
        end
        cake_x = {3'b0, gx};
        cake_y = {3'b0, gy};
        head_x = 12'hFFF;
        head_y = 12'hFFF;
    endtask

    initial begin
        int strobes;
        bit saw_255, saw_wrap;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            game_en = 1'($urandom);
            head_x  = 12'($urandom);
            head_y  = 12'($urandom);
            cake_x  = head_x;
            cake_y  = head_y;
            @(negedge clk);
            chk("rst_num", rand_num, 0);
            chk("rst_drive", rand_drive, 0);
            chk("rst_eat", eat_pulse, 0);
            chk("rst_score", score, 0);
        end
        rst_n = 1'b1;
        game_en = 1'b1;
        head_x = 12'd100; head_y = 12'd100; cake_x = 12'd300; cake_y = 12'd300;
        strobes = 0;
        repeat (50) begin
            @(negedge clk);
            strobes += int'(eat_pulse) + int'(rand_drive) + int'(eat_pulse_nr) + int'(rand_drive_nr);
        end
        chk("idle_no_strobes", strobes, 0);
        game_en = 1'b0;
        head_x = 12'd300; head_y = 12'd300;
        strobes = 0;
        repeat (100) begin
            @(negedge clk);
            strobes += int'(eat_pulse) + int'(rand_drive);
        end
        chk("disabled_no_strobes", strobes, 0);
        chk("disabled_score", score, 0);
        game_en = 1'b1;
        do_eat(1'b0, 1'b0);
        chk("single_score", score, 1);
        do_eat(1'b1, 1'b0);
        do_eat(1'b0, 1'b1);
        do_eat(1'b0, 1'b0);
        chk("after_reset_score", score, 1);
        tot_ep = 0;
        tot_rd = 0;
        saw_255 = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 256; i++) begin
            do_eat(1'b0, 1'b0);
            if (saw_255 && score == 8'd0) saw_wrap = 1'b1;
            saw_255 = (score == 8'd255);
        end
        chk("wrap_255_to_0", saw_wrap, 1);
        chk("wrap_eat_pulses", tot_ep, 256);
        chk("wrap_drives", tot_rd, 256);
        chk("wrap_score", score, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
